binary_div_13_7_seq: RTL
========================

Name: binary_div_13_7_seq

Overview:
Sequential signed divider; the inverse datapath of the team's 7x7 signed array multiplier. Takes a 13-bit signed dividend (multiplier product width) and a 7-bit signed divisor (multiplicand width). Produces a truncating quotient and remainder through a start/busy/done handshake. Used to recover an operand from a registered product, and as a general small-width divider beside the multiplier.

Parameters:
DW, 13, dividend and quotient width (signed two's complement); also the iteration count.
VW, 7, divisor and remainder width (signed two's complement).

Ports:
clk  input  1  rising-edge clock, the block's only clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  clock enable; when low, all state and outputs hold
start  input  1  request; sampled only in IDLE with en=1
dividend  input  DW  signed dividend, captured on accepted start
divisor  input  VW  signed divisor, captured on accepted start
busy  output  1  high from the accept edge until done is raised
done  output  1  one-cycle pulse: result valid
quotient  output  DW  signed quotient, truncated toward zero
remainder  output  VW  signed remainder, sign of dividend
div_zero  output  1  divisor was 0 for this result
ovf  output  1  quotient not representable (-2^(DW-1) / -1)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. On reset, busy, done, quotient, remainder, div_zero and ovf are all 0, and the FSM goes to IDLE. Reset mid-operation aborts with no done pulse.
- en=0: no state, counter or output register changes. done holds its current value for the stalled cycles. Latency stretches by the number of stalled cycles.
- FSM states: IDLE, CALC, FIX.
- IDLE -> CALC on start=1 and en=1 with divisor != 0.
  - Capture |dividend| (DW+1 bits, so -4096 is handled) and |divisor|.
  - Capture the result signs: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
  - Clear the partial remainder and load count = DW. Set busy=1.
- IDLE -> FIX on accepted start with divisor == 0, skipping CALC.
- CALC: one restoring step per enabled cycle.
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement count. Go to FIX after the step that brings count to 0, i.e. exactly DW steps.
- FIX: register the sign-corrected quotient and remainder, and set div_zero and ovf. Then busy=0, done=1 for one enabled cycle, and return to IDLE.
- Divide by zero: quotient=0, remainder=0, div_zero=1, ovf=0.
- Overflow: dividend=-2^(DW-1) with divisor=-1 gives quotient=-2^(DW-1) (wrapped), remainder=0, ovf=1.
- Otherwise div_zero=0 and ovf=0.
- Latency with en held high, counting edges from the start-accept edge E:
  - Normal: CALC steps on E+1..E+DW and FIX on E+DW+1, so done is high in the cycle after edge E+14.
  - Divide by zero: FIX on E+1, so done is high in the cycle after E+1.
- start while busy, or start in the done cycle before IDLE is re-entered: ignored, no queueing. start is accepted again once the FSM is in IDLE.
- Result registers and flags hold after done until the next FIX writes them. They are not cleared on start.
- Width rules: |divisor| ≤ 64, so |remainder| ≤ 63 and always fits VW signed bits. The quotient magnitude is computed in DW+1 bits, then truncated to DW bits.

Decomposition:
- Shared package holds:
  - DW and VW defaults.
  - State enum {IDLE, CALC, FIX}.
  - Counter width, $clog2(DW+1).
  - Constant DIV0_QUOT = 0.
- One sub-module, div_restore_step: combinational single-iteration shift, trial-subtract and select. It takes partial remainder, incoming bit and |divisor|, and returns the new remainder and the quotient bit. Instantiated once inside the sequential loop.

Test Plan:
- dividend=-3969, divisor=63, start pulse, en=1 -> done exactly 15 cycles after accept; quotient=-63, remainder=0, flags 0.
- 100/-7 -> quotient=-14, remainder=2. Then -100/7 -> quotient=-14, remainder=-2. Back-to-back starts, each accepted in IDLE.
- 5/0 -> done 2 cycles after accept; div_zero=1, quotient=0, remainder=0, ovf=0. Next op 12/3 -> quotient=4, div_zero=0.
- -4096/-1 -> ovf=1, quotient=13'h1000, remainder=0. Also 4095/1 -> quotient=4095, ovf=0.
- 100/-7 with start re-pulsed on cycles 3 and 8 of busy, and en=0 for 3 cycles during CALC -> extra starts ignored; done on cycle 18 with quotient=-14, remainder=2.
- rst_n asserted on CALC step 6 -> all outputs 0 immediately, no done pulse. After release, 48/6 completes normally with quotient=8, remainder=0.

Source files
------------

// File: rtl/binary_div_13_7_seq_pkg.sv
// rtl/binary_div_13_7_seq_pkg.sv - shared widths, FSM states and constants for the sequential signed divider
package binary_div_13_7_seq_pkg;

  localparam int DEF_DW = 13;
  localparam int DEF_VW = 7;

  // Iteration counter must hold the value DW itself.
  localparam int CNT_W = $clog2(DEF_DW + 1);

  // Quotient reported when the divisor is zero.
  localparam int DIV0_QUOT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/binary_div_13_7_seq_div_restore_step.sv
// rtl/binary_div_13_7_seq_div_restore_step.sv - one restoring-division iteration: shift, trial-subtract, select
module div_restore_step
  import binary_div_13_7_seq_pkg::*;
#(
  parameter int VW = DEF_VW
) (
  input  logic [VW-1:0] prem,
  input  logic          bit_in,
  input  logic [VW-1:0] dmag,
  output logic [VW-1:0] rem_nxt,
  output logic          qbit
);

  // prem < dmag <= 2^(VW-1), so the shifted value needs one extra bit,
  // while both the difference and the restored value fit back in VW bits.
  logic [VW:0]   shifted;
  logic [VW-1:0] diff;

  assign shifted = {prem, bit_in};
  assign qbit    = (shifted >= {1'b0, dmag});
  assign diff    = shifted[VW-1:0] - dmag;
  assign rem_nxt = qbit ? diff : shifted[VW-1:0];

endmodule

// File: rtl/binary_div_13_7_seq.sv
// rtl/binary_div_13_7_seq.sv - sequential signed divider, truncating quotient, start/busy/done handshake
module binary_div_13_7_seq
  import binary_div_13_7_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic          ovf
);

  localparam int CW = $clog2(DW + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [DW-1:0] dvd;       // dividend magnitude, quotient bits shift in from the bottom
  logic [VW-1:0] dmag;
  logic [VW-1:0] prem;
  logic          q_neg, r_neg, dz;

  logic [DW-1:0] dvd_abs;
  logic [VW-1:0] dvs_abs;
  logic [VW-1:0] rem_nxt;
  logic          qbit;
  logic          take;
  logic [DW-1:0] q_signed;
  logic [VW-1:0] r_signed;

  // Magnitudes as unsigned: -2^(DW-1) negates to itself, which is the correct unsigned magnitude.
  assign dvd_abs  = dividend[DW-1] ? -dividend : dividend;
  assign dvs_abs  = divisor[VW-1] ? -divisor : divisor;
  assign take     = start && (state == IDLE) && !done;
  assign q_signed = q_neg ? -dvd : dvd;
  assign r_signed = r_neg ? -prem : prem;

  div_restore_step #(.VW(VW)) u_step (
    .prem    (prem),
    .bit_in  (dvd[DW-1]),
    .dmag    (dmag),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // State register, frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= IDLE;
    else if (en) state <= state_nxt;
  end

  // Next-state: zero divisor skips straight to FIX; CALC ends on the step that empties count.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = (divisor == '0) ? FIX : CALC;
      CALC:    if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers: capture on accept, iterate in CALC, sign-correct in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      dvd       <= '0;
      dmag      <= '0;
      prem      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (take) begin
            busy  <= 1'b1;
            dvd   <= dvd_abs;
            dmag  <= dvs_abs;
            prem  <= '0;
            count <= CW'(DW);
            q_neg <= dividend[DW-1] ^ divisor[VW-1];
            r_neg <= dividend[DW-1];
            dz    <= (divisor == '0);
          end
        end
        CALC: begin
          dvd   <= {dvd[DW-2:0], qbit};
          prem  <= rem_nxt;
          count <= count - CW'(1);
        end
        FIX: begin
          quotient  <= dz ? DW'(DIV0_QUOT) : q_signed;
          remainder <= dz ? '0 : r_signed;
          div_zero  <= dz;
          // A positive quotient with its top bit set can only be -2^(DW-1) / -1.
          ovf       <= !dz && !q_neg && dvd[DW-1];
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
